// File: rtl/rock_setpoint_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rock_pkg
//  Description : Shared types and default constants for the cradle rocking
//                setpoint controller (state encoding, counter width, initial
//                and maximum setpoints, ramp prescaler divide).
//  Revision    : 1.0  initial release
// ============================================================================
package rock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RAMP = 2'd2
    } state_t;

    localparam int c_def_w        = 3;
    localparam int c_def_f_init   = 5;
    localparam int c_def_a_init   = 5;
    localparam int c_def_f_max    = 7;
    localparam int c_def_a_max    = 7;
    localparam int c_def_ramp_div = 4;

endpackage : rock_pkg
`default_nettype wire

// File: rtl/rock_setpoint_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rock_setpoint_ctrl_if
//  Description : Operator command / setpoint bundle of the rocking controller.
//                master : drives start, stop, f_up, f_down, a_up, a_down;
//                         observes F, A, F0, AF0, busy, ramping, done.
//                slave  : the controller side (directions reversed).
//  Revision    : 1.0  initial release
// ============================================================================
interface rock_setpoint_ctrl_if #(
    parameter int W = 3
);
    logic         start;
    logic         stop;
    logic         f_up;
    logic         f_down;
    logic         a_up;
    logic         a_down;
    logic [W-1:0] F;
    logic [W-1:0] A;
    logic         F0;
    logic         AF0;
    logic         busy;
    logic         ramping;
    logic         done;

    modport master (
        output start, stop, f_up, f_down, a_up, a_down,
        input  F, A, F0, AF0, busy, ramping, done
    );

    modport slave (
        input  start, stop, f_up, f_down, a_up, a_down,
        output F, A, F0, AF0, busy, ramping, done
    );
endinterface : rock_setpoint_ctrl_if
`default_nettype wire

// File: rtl/rock_setpoint_ctrl_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_updown_counter
//  Description : W-bit up/down counter saturating at 0 and MAX (never wraps).
//                Ports: clk, reset (async, active-low, loads INIT),
//                load (reload INIT), inc / dec (operator step, both = hold),
//                dec_force (ramp step, overrides inc/dec), q (count).
//  Revision    : 1.0  initial release
// ============================================================================
module sat_updown_counter #(
    parameter int W    = 3,
    parameter int INIT = 5,
    parameter int MAX  = 7
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         load,
    input  wire logic         inc,
    input  wire logic         dec,
    input  wire logic         dec_force,
    output logic [W-1:0]      q
);
    localparam logic [W-1:0] c_init = W'(INIT);
    localparam logic [W-1:0] c_max  = W'(MAX);
    localparam logic [W-1:0] c_zero = '0;
    localparam logic [W-1:0] c_one  = W'(1);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= c_init;
        end else if (load) begin
            r_q <= c_init;
        end else if (dec_force) begin
            if (r_q != c_zero) r_q <= r_q - c_one;
        end else if (inc && !dec) begin
            // Limit compare, not carry-out: MAX may be below 2^W-1.
            if (r_q < c_max) r_q <= r_q + c_one;
        end else if (dec && !inc) begin
            if (r_q != c_zero) r_q <= r_q - c_one;
        end
    end

    assign q = r_q;

endmodule : sat_updown_counter
`default_nettype wire

// File: rtl/rock_setpoint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rock_setpoint_ctrl
//  Description : Frequency (F) / amplitude (A) setpoint controller for the
//                cradle drive with IDLE/RUN/RAMP start-stop sequencing.
//                A stop ramps A to 0 then F to 0, one step every RAMP_DIV
//                clocks, then pulses done and returns to IDLE.
//  Ports       : clk    - system clock (rising edge)
//                reset  - asynchronous reset, active low
//                bus    - rock_setpoint_ctrl_if.slave (commands in,
//                         F/A setpoints and status flags out)
//  Options     : ROCK_EDGE_DETECT_EN - rising-edge detect f_up/f_down/
//                a_up/a_down (one step per press) instead of level-sensitive.
//  Revision    : 1.0  initial release
// ============================================================================
module rock_setpoint_ctrl
    import rock_pkg::*;
#(
    parameter int W        = c_def_w,
    parameter int F_INIT   = c_def_f_init,
    parameter int A_INIT   = c_def_a_init,
    parameter int F_MAX    = c_def_f_max,
    parameter int A_MAX    = c_def_a_max,
    parameter int RAMP_DIV = c_def_ramp_div
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rock_setpoint_ctrl_if.slave bus
);
    // Prescaler needs at least one bit even when RAMP_DIV == 1.
    localparam int              c_pw     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_pw-1:0] c_tc     = c_pw'(RAMP_DIV - 1);
    localparam logic [W-1:0]    c_zero_w = '0;

    state_t          r_state, w_state_nxt;
    logic [c_pw-1:0] r_presc, w_presc_nxt;
    logic            r_done,  w_done_nxt;

    logic            w_load;
    logic            w_f_inc, w_f_dec, w_f_force;
    logic            w_a_inc, w_a_dec, w_a_force;
    logic [W-1:0]    w_f_q, w_a_q;

    // {f_up, f_down, a_up, a_down} after optional edge detection
    logic [3:0]      w_btn;

`ifdef ROCK_EDGE_DETECT_EN
    logic [3:0]      r_btn_prev;

    // Previous-sample registers clear to 0 so a button already held at
    // reset release is seen as a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_btn_prev <= 4'b0000;
        else        r_btn_prev <= {bus.f_up, bus.f_down, bus.a_up, bus.a_down};
    end

    assign w_btn = {bus.f_up, bus.f_down, bus.a_up, bus.a_down} & ~r_btn_prev;
`else
    assign w_btn = {bus.f_up, bus.f_down, bus.a_up, bus.a_down};
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ---------------- next state / counter controls ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_f_inc     = 1'b0;
        w_f_dec     = 1'b0;
        w_f_force   = 1'b0;
        w_a_inc     = 1'b0;
        w_a_dec     = 1'b0;
        w_a_force   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end

            RUN: begin
                if (bus.stop) begin
                    // Commands arriving with stop are dropped.
                    w_state_nxt = RAMP;
                    w_presc_nxt = '0;
                end else begin
                    w_f_inc = w_btn[3];
                    w_f_dec = w_btn[2];
                    w_a_inc = w_btn[1];
                    w_a_dec = w_btn[0];
                end
            end

            RAMP: begin
                if (r_presc == c_tc) begin
                    w_presc_nxt = '0;
                    // Amplitude first, then frequency; both zero ends the ramp.
                    if (w_a_q != c_zero_w) begin
                        w_a_force = 1'b1;
                    end else if (w_f_q != c_zero_w) begin
                        w_f_force = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_presc_nxt = '0;
            end
        endcase
    end

    // ---------------- setpoint counters ----------------
    sat_updown_counter #(
        .W    (W),
        .INIT (F_INIT),
        .MAX  (F_MAX)
    ) u_f_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .inc       (w_f_inc),
        .dec       (w_f_dec),
        .dec_force (w_f_force),
        .q         (w_f_q)
    );

    sat_updown_counter #(
        .W    (W),
        .INIT (A_INIT),
        .MAX  (A_MAX)
    ) u_a_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .inc       (w_a_inc),
        .dec       (w_a_dec),
        .dec_force (w_a_force),
        .q         (w_a_q)
    );

    // ---------------- outputs ----------------
    assign bus.F       = w_f_q;
    assign bus.A       = w_a_q;
    assign bus.F0      = (w_f_q == c_zero_w);
    assign bus.AF0     = (w_f_q == c_zero_w) && (w_a_q == c_zero_w);
    assign bus.busy    = (r_state == RUN) || (r_state == RAMP);
    assign bus.ramping = (r_state == RAMP);
    assign bus.done    = r_done;

endmodule : rock_setpoint_ctrl
`default_nettype wire

// File: tb/tb_rock_setpoint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rock_setpoint_ctrl
//  Description : Directed, table-driven bench for rock_setpoint_ctrl with
//                default parameters (W=3, INIT=5, MAX=7, RAMP_DIV=4).
//                Expected values that differ between the level build and the
//                ROCK_EDGE_DETECT_EN build are selected with TB_SEL.
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef ROCK_EDGE_DETECT_EN
`define TB_SEL(lv, ed) (ed)
`else
`define TB_SEL(lv, ed) (lv)
`endif

module tb_rock_setpoint_ctrl;

    logic clk;
    logic reset;

    rock_setpoint_ctrl_if #(.W(3)) bus ();

    rock_setpoint_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic st, sp, fu, fd, au, ad;
        int   ef, ea;
        logic eb, er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, sp, fu, fd, au, ad,
                                input int ef, ea, input logic eb, er);
        vec_t v;
        v.st = st; v.sp = sp; v.fu = fu; v.fd = fd; v.au = au; v.ad = ad;
        v.ef = ef; v.ea = ea; v.eb = eb; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ef, ea,
                           input logic eb, er, ed);
        chk({tag, " F"},       32'(bus.F),       32'(ef));
        chk({tag, " A"},       32'(bus.A),       32'(ea));
        chk({tag, " F0"},      32'(bus.F0),      32'(ef == 0));
        chk({tag, " AF0"},     32'(bus.AF0),     32'(ef == 0 && ea == 0));
        chk({tag, " busy"},    32'(bus.busy),    32'(eb));
        chk({tag, " ramping"}, 32'(bus.ramping), 32'(er));
        chk({tag, " done"},    32'(bus.done),    32'(ed));
    endtask

    task automatic drive(input logic st, sp, fu, fd, au, ad);
        bus.start = st; bus.stop = sp;
        bus.f_up = fu;  bus.f_down = fd;
        bus.a_up = au;  bus.a_down = ad;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reset, start, then stop: on return the DUT has just entered RAMP.
    task automatic start_then_stop();
        do_reset();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int steps, ef, ea;

        // ---------------- table: IDLE / RUN command behaviour ----------------
        vecs.push_back(mk(0,1,1,0,1,0, 5, 5, 0,0));                               // 0 IDLE ignores cmds
        vecs.push_back(mk(0,0,0,0,0,1, 5, 5, 0,0));                               // 1
        vecs.push_back(mk(1,0,0,0,0,0, 5, 5, 1,0));                               // 2 start
        vecs.push_back(mk(0,0,1,0,0,0, 6, 5, 1,0));                               // 3 f_up
        vecs.push_back(mk(0,0,1,0,0,0, `TB_SEL(7,6), 5, 1,0));                    // 4
        vecs.push_back(mk(0,0,1,0,0,0, `TB_SEL(7,6), 5, 1,0));                    // 5 saturate
        vecs.push_back(mk(0,0,0,0,0,0, `TB_SEL(7,6), 5, 1,0));                    // 6
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,1,1,0,0, `TB_SEL(7,6), 5, 1,0));                // 7-10 up+down hold
        vecs.push_back(mk(0,0,0,0,0,1, `TB_SEL(7,6), 4, 1,0));                    // 11 a_down
        vecs.push_back(mk(0,0,0,0,0,1, `TB_SEL(7,6), `TB_SEL(3,4), 1,0));         // 12
        vecs.push_back(mk(0,0,0,0,0,1, `TB_SEL(7,6), `TB_SEL(2,4), 1,0));         // 13
        vecs.push_back(mk(0,0,0,0,0,1, `TB_SEL(7,6), `TB_SEL(1,4), 1,0));         // 14
        vecs.push_back(mk(0,0,0,0,0,1, `TB_SEL(7,6), `TB_SEL(0,4), 1,0));         // 15
        vecs.push_back(mk(0,0,0,0,0,1, `TB_SEL(7,6), `TB_SEL(0,4), 1,0));         // 16 floor
        vecs.push_back(mk(0,0,0,0,0,0, `TB_SEL(7,6), `TB_SEL(0,4), 1,0));         // 17
        vecs.push_back(mk(0,0,0,0,1,0, `TB_SEL(7,6), `TB_SEL(1,5), 1,0));         // 18 a_up
        vecs.push_back(mk(0,0,0,1,0,0, `TB_SEL(6,5), `TB_SEL(1,5), 1,0));         // 19 f_down
        vecs.push_back(mk(1,0,0,0,0,0, `TB_SEL(6,5), `TB_SEL(1,5), 1,0));         // 20 start in RUN
        vecs.push_back(mk(0,1,1,0,0,1, `TB_SEL(6,5), `TB_SEL(1,5), 1,1));         // 21 stop drops cmds
        vecs.push_back(mk(1,0,1,0,1,0, `TB_SEL(6,5), `TB_SEL(1,5), 1,1));         // 22 RAMP ignores cmds

        bus.start = 0;
        do_reset();
        chk_all("reset", 5, 5, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].fu, vecs[i].fd, vecs[i].au, vecs[i].ad);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ea, vecs[i].eb, vecs[i].er, 1'b0);
        end

        // ---------------- full ramp-down from F=5, A=5 ----------------
        start_then_stop();
        chk_all("ramp c0", 5, 5, 1, 1, 0);
        for (int c = 1; c <= 45; c++) begin
            drive((c % 3 == 0) && (c < 40), (c % 5 == 0) && (c < 40),
                  (c % 2 == 1) && (c < 40), 0, (c < 40), 0);
            tick();
            if (c <= 43) begin
                steps = c / 4;
                ea = (steps >= 5) ? 0 : 5 - steps;
                ef = (steps <= 5) ? 5 : ((steps >= 10) ? 0 : 10 - steps);
                chk_all($sformatf("ramp c%0d", c), ef, ea, 1, 1, 0);
            end else if (c == 44) begin
                chk_all("ramp done", 0, 0, 0, 0, 1);
            end else begin
                chk_all("ramp after", 0, 0, 0, 0, 0);
            end
        end

        // ---------------- asynchronous reset mid-ramp at A=2 ----------------
        start_then_stop();
        repeat (12) tick();
        chk_all("pre-abort", 5, 2, 1, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async abort", 5, 5, 0, 0, 0);
        tick();
        chk_all("abort held", 5, 5, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk_all("abort released", 5, 5, 0, 0, 0);

        // ---------------- ramp entered with A=F=0 ----------------
        do_reset();
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0, 1); tick();
            drive(0, 0, 0, 0, 0, 0); tick();
        end
        chk_all("zero run", 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk_all($sformatf("zero ramp c%0d", c), 0, 0, 1, 1, 0);
        end
        tick();
        chk_all("zero done", 0, 0, 0, 0, 1);
        tick();
        chk_all("zero after", 0, 0, 0, 0, 0);

        // ---------------- held f_up for 10 cycles ----------------
        do_reset();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0);
        repeat (10) tick();
        chk_all("held f_up", `TB_SEL(7,6), 5, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rock_setpoint_ctrl

`undef TB_SEL
`default_nettype wire

// File: doc/rock_setpoint_ctrl.md
Name: rock_setpoint_ctrl

Overview:
- Parametrised amplitude/frequency setpoint controller for the cradle drive; successor of the current fixed 3-bit F/A counter block.
- Holds frequency setpoint F and amplitude setpoint A. Both are saturating up/down counters, driven by operator commands while running.
- Adds a start/stop state machine with a controlled ramp-down on stop: A falls to 0 first, then F falls to 0. Each decrement is paced by a prescaler.
- Feeds the motor PWM/timing generator; F0/AF0 keep their existing meaning for downstream logic.

Parameters:
- W, 3, width of F and A.
- F_INIT, 5, value loaded into F on reset and on start.
- A_INIT, 5, value loaded into A on reset and on start.
- F_MAX, 7, upper saturation limit of F; must be ≤ 2^W-1.
- A_MAX, 7, upper saturation limit of A; must be ≤ 2^W-1.
- RAMP_DIV, 4, clock cycles per ramp decrement step; must be ≥ 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  begin rocking.
- stop  in  1  request controlled ramp-down.
- f_up  in  1  increment F.
- f_down  in  1  decrement F.
- a_up  in  1  increment A.
- a_down  in  1  decrement A.
- F  out  W  frequency setpoint (registered).
- A  out  W  amplitude setpoint (registered).
- F0  out  1  F == 0 (combinational from register).
- AF0  out  1  F == 0 and A == 0.
- busy  out  1  state is RUN or RAMP.
- ramping  out  1  state is RAMP.
- done  out  1  one-cycle pulse when ramp completes.

Behaviour:
- Reset: state=IDLE, F=F_INIT, A=A_INIT, done=0. F0, AF0, busy and ramping follow from these values. Reset mid-ramp aborts immediately to the same values.
- States: IDLE, RUN, RAMP. All registers update on the rising edge of clk.
- IDLE:
  - f_*/a_*/stop are ignored.
  - start=1 → load F=F_INIT, A=A_INIT and enter RUN next cycle.
- RUN, in priority order:
  - stop=1 → enter RAMP. Commands in that same cycle are ignored. The prescaler clears to 0.
  - Otherwise, F and A update independently each cycle:
    - up only → +1, saturating at F_MAX/A_MAX.
    - down only → -1, saturating at 0.
    - up and down together → hold.
  - start in RUN is ignored.
- RAMP:
  - Prescaler counts 0..RAMP_DIV-1. On a terminal-count cycle, exactly one decrement occurs: A-1 if A>0, else F-1 if F>0.
  - When A==0 and F==0 at a terminal count → enter IDLE; done=1 for that one cycle.
  - The first decrement happens RAMP_DIV cycles after entering RAMP.
  - If A=F=0 on entry → done occurs after RAMP_DIV cycles.
  - start, stop and f_*/a_* are ignored in RAMP.
- Arithmetic: counters are W bits and never wrap. Saturation is checked against the limits, not against 2^W.
- Latency: a command is visible on F/A one cycle after the sampling edge.
- Flags are combinational decodes of the registers, with no extra latency.

Optional Feature:
- Macro: ROCK_EDGE_DETECT_EN.
- Defined: f_up, f_down, a_up and a_down are rising-edge detected with one register stage each. A held button gives exactly one step. Simultaneous rising edges of up and down → hold. The edge registers reset to 0, so an input already high at reset release counts as an edge.
- Undefined: level-sensitive; one step per cycle while the input is high.
- start and stop are level-sensitive in both builds.

Decomposition:
- Package rock_pkg: state enum (IDLE, RUN, RAMP), encoded in 2 bits; shared default constants (W, INIT and MAX values).
- Sub-module sat_updown_counter: parameters W, INIT, MAX; ports clk, reset, load, inc, dec, dec_force, q. Instantiated twice, once for F and once for A. The parent FSM drives load, inc, dec and the ramp decrement.

Test Plan:
- Reset then start, 3 cycles f_up → F 5→6→7→7 (saturates); A stays 5; busy=1.
- RUN, f_up=f_down=1 for 4 cycles → F unchanged; a_down 6 cycles from 5 → A 4,3,2,1,0,0.
- RUN with F=5, A=5, stop pulse, RAMP_DIV=4 → A decrements at cycles 4,8,…,20 to 0; F decrements at 24..40 to 0; AF0=1 at 40; done pulses at 44 with state IDLE.
- Reset asserted (reset=0) mid-RAMP at A=2 → F=5, A=5 and state IDLE immediately (asynchronous); done stays 0.
- ROCK_EDGE_DETECT_EN build: f_up held 10 cycles → F +1 only; level build: F saturates at F_MAX.
- IDLE with f_up/a_up/stop toggling → no change on F/A; start in RAMP → no effect.
